// File: rtl/iq_carrier_nco.sv
// iq_carrier_nco: phase-accumulator NCO producing offset-binary I (cosine)
// and Q (sine) carriers from a single cosine table. The FCW is reprogrammable,
// the phase can be re-synchronised, and a strobe marks accumulator wrap.
module iq_carrier_nco #(
  parameter int PHASE_W = 16,
  parameter int IDX_W   = 4,
  parameter int DATA_W  = 8,
  parameter int AMP     = 100,
  parameter int OFFSET  = 100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [PHASE_W-1:0] fcw_in,
  input  logic               fcw_load,
  input  logic               phase_sync,
  output logic [DATA_W-1:0]  i_out,
  output logic [DATA_W-1:0]  q_out,
  output logic               out_valid,
  output logic               wrap
);

  // ---------------------------------------------------------------------------
  // Table geometry and fixed-point constants for elaboration-time ROM build
  // ---------------------------------------------------------------------------
  localparam int N   = 1 << IDX_W;
  localparam int QTR = N / 4;

  // The ROM is computed with integer fixed-point maths so that every tool
  // evaluates it identically; 30 fractional bits keep the Taylor-series error
  // far below the half-LSB rounding threshold of any practical DATA_W.
  localparam int     SCALE_W      = 30;
  localparam longint ONE_FX       = 64'sd1 << SCALE_W;
  localparam longint PI_HALF_FX   = 64'sd1686629713; // round(pi/2 * 2^30)
  localparam int     TAYLOR_TERMS = 12;
  localparam longint SAMPLE_MAX   = (64'sd1 << DATA_W) - 64'sd1;

  localparam logic [PHASE_W-1:0] FCW_DEFAULT =
    {{(PHASE_W-1){1'b0}}, 1'b1} << (PHASE_W - IDX_W);

  // cos(2*pi*j/N) for 0 <= j <= N/4, scaled by 2^SCALE_W.
  // The angle never exceeds pi/2, so a short Maclaurin series converges fast.
  function automatic longint cos_first_quadrant(input int j);
    longint x;
    longint term;
    longint sum;
    x    = (PI_HALF_FX * longint'(j)) / longint'(QTR);
    term = ONE_FX;
    sum  = ONE_FX;
    for (int n = 1; n <= TAYLOR_TERMS; n++) begin
      term = (term * x) / ONE_FX;
      term = (term * x) / ONE_FX;
      term = -term / longint'((2 * n - 1) * (2 * n));
      sum  = sum + term;
    end
    return sum;
  endfunction

  // Full-period cosine table built from the first quadrant by symmetry,
  // rounded half-up to the nearest output code and packed flat.
  function automatic logic [N*DATA_W-1:0] build_rom();
    logic [N*DATA_W-1:0] rom;
    longint              c;
    longint              val;
    int                  quad;
    int                  r;
    rom = '0;
    for (int k = 0; k < N; k++) begin
      quad = k / QTR;
      r    = k % QTR;
      case (quad)
        0:       c =  cos_first_quadrant(r);
        1:       c = -cos_first_quadrant(QTR - r);
        2:       c = -cos_first_quadrant(r);
        default: c =  cos_first_quadrant(QTR - r);
      endcase
      val = longint'(OFFSET) * ONE_FX + longint'(AMP) * c + ONE_FX / 2;
      val = val / ONE_FX;
      if (val < 0)          val = 0;
      if (val > SAMPLE_MAX) val = SAMPLE_MAX;
      rom[k*DATA_W +: DATA_W] = val[DATA_W-1:0];
    end
    return rom;
  endfunction

  localparam logic [N*DATA_W-1:0] ROM_FLAT = build_rom();

  // ---------------------------------------------------------------------------
  // Cosine table, unpacked for indexed reads
  // ---------------------------------------------------------------------------
  // NOTE: the table is a constant, not storage, so it has no reset and no
  // write port; only the datapath registers below are reset.
  logic [DATA_W-1:0] rom_tbl [N];

  for (genvar g = 0; g < N; g++) begin : g_rom
    assign rom_tbl[g] = ROM_FLAT[g*DATA_W +: DATA_W];
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PHASE_W-1:0] acc_q, acc_d;
  logic [PHASE_W-1:0] fcw_q, fcw_d;
  logic [DATA_W-1:0]  i_q,   i_d;
  logic [DATA_W-1:0]  q_q,   q_d;
  logic               valid_q, valid_d;
  logic               wrap_q,  wrap_d;

  // ---------------------------------------------------------------------------
  // Phase arithmetic
  // ---------------------------------------------------------------------------
  logic [PHASE_W:0]   sum_ext;
  logic [PHASE_W-1:0] acc_sum;
  logic               acc_carry;
  logic [IDX_W-1:0]   i_idx;
  logic [IDX_W-1:0]   q_idx;

  // Accumulator increment with its carry kept as the wrap indication.
  assign sum_ext   = {1'b0, acc_q} + {1'b0, fcw_q};
  assign acc_sum   = sum_ext[PHASE_W-1:0];
  assign acc_carry = sum_ext[PHASE_W];

  // Sine is the cosine a quarter period earlier; the subtraction wraps
  // naturally in IDX_W bits.
  assign i_idx = acc_q[PHASE_W-1 -: IDX_W];
  assign q_idx = i_idx - IDX_W'(QTR);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // Compute next accumulator, FCW and output sample for the coming edge.
  always_comb begin
    // NOTE: every signal gets a default first so no path can leave one
    // unassigned, which would otherwise infer a latch.
    acc_d   = acc_q;
    fcw_d   = fcw_q;
    i_d     = i_q;
    q_d     = q_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;

    // The increment below always sees the old FCW; the loaded value
    // becomes effective from the following edge.
    if (fcw_load) begin
      fcw_d = fcw_in;
    end

    if (en) begin
      i_d     = rom_tbl[i_idx];
      q_d     = rom_tbl[q_idx];
      valid_d = 1'b1;
      if (phase_sync) begin
        acc_d  = '0;
        wrap_d = 1'b0;
      end else begin
        acc_d  = acc_sum;
        wrap_d = acc_carry;
      end
    end else if (phase_sync) begin
      acc_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // Single register bank with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values,
    // independent of statement order.
    if (!rst_n) begin
      acc_q   <= '0;
      fcw_q   <= FCW_DEFAULT;
      i_q     <= '0;
      q_q     <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      fcw_q   <= fcw_d;
      i_q     <= i_d;
      q_q     <= q_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign i_out     = i_q;
  assign q_out     = q_q;
  assign out_valid = valid_q;
  assign wrap      = wrap_q;

endmodule

// File: doc/iq_carrier_nco.md
# iq_carrier_nco

Parametrised I/Q carrier generator for the modulator datapath. It supersedes the fixed 16-step in-phase cosine generator. A programmable phase accumulator indexes a cosine ROM and produces both the in-phase (cosine) and quadrature (sine) carriers in offset-binary form. It also provides runtime frequency control, phase re-synchronisation, a clock enable and a per-cycle wrap strobe. It feeds the I and Q mixers directly.

## Interface
- PHASE_W, 16, phase accumulator width in bits.
- IDX_W, 4, table index width; the table holds N = 2^IDX_W samples per carrier period. Legal range: 2 <= IDX_W <= PHASE_W.
- DATA_W, 8, output sample width.
- AMP, 100, peak amplitude.
- OFFSET, 100, mid-scale value. Requires OFFSET >= AMP and OFFSET+AMP <= 2^DATA_W-1.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- en  in  1  advance enable.
- fcw_in  in  PHASE_W  frequency control word.
- fcw_load  in  1  capture fcw_in into the FCW register.
- phase_sync  in  1  clear the phase accumulator.
- i_out  out  DATA_W  in-phase sample, OFFSET + AMP·cos(2πk/N).
- q_out  out  DATA_W  quadrature sample, OFFSET + AMP·sin(2πk/N).
- out_valid  out  1  i_out/q_out hold a sample produced this cycle.
- wrap  out  1  one-cycle strobe; the accumulator increment this cycle carried out.

## Operation
- ROM: N entries, entry k = round(OFFSET + AMP·cos(2πk/N)), fixed at elaboration.
  - Defaults give 200,192,171,138,100,62,29,8,0,8,29,62,100,138,171,192.
- Phase index: k = acc[PHASE_W-1 -: IDX_W], i.e. the top IDX_W bits of the accumulator.
- i_out reads ROM[k].
- q_out reads ROM[(k − N/4) mod N], using IDX_W-bit wrap-around subtraction.
- Accumulator: acc <= acc + fcw, modulo 2^PHASE_W. The carry out of this addition drives wrap.
- FCW register:
  - Reset value is 1 << (PHASE_W−IDX_W), which advances one table step per clock.
  - fcw_load=1 captures fcw_in. The new value is used from the next clock onward.
  - fcw = 0 is legal and gives constant outputs.
- Per rising edge, in priority order:
  - rst_n=0: acc=0, fcw=default, i_out=0, q_out=0, out_valid=0, wrap=0. All other inputs are ignored.
  - Otherwise, when en=1:
    - i_out and q_out are registered from the current (pre-increment) acc.
    - out_valid=1.
    - wrap is the carry of acc+fcw.
    - acc <= acc+fcw, unless phase_sync=1, in which case acc <= 0 and wrap=0.
  - Otherwise, when en=0:
    - i_out and q_out hold their values.
    - out_valid=0, wrap=0.
    - acc holds, unless phase_sync=1, which clears it to 0.
- Simultaneous events:
  - fcw_load together with phase_sync: both take effect.
  - fcw_load together with en: this cycle's increment uses the old fcw.
- Reset mid-stream takes effect at the next edge. The first enabled cycle after reset outputs ROM[0] on i_out and ROM[3N/4] on q_out.

## Timing
- One-cycle latency: the sample registered at edge t reflects acc as it was before edge t.
- Frequency change: fcw_load at edge t → the increment at edge t+1 uses the new FCW → the first sample at the new rate appears at edge t+2.
- phase_sync at edge t → the sample at edge t+1 (with en=1) is i_out=ROM[0], q_out=ROM[3N/4].
- wrap is high in the same cycle as the output sample whose increment overflowed. With the default FCW that is the sample with k = N−1.
- All outputs are registered. There is no combinational path from input to output.

## Test plan
- Reset, then en=1 with defaults → i_out sequence 200,192,171,138,100,62,29,8,0,…,192 repeating every 16 clocks.
  - q_out = 100,138,171,192,200,192,171,138,100,… over the same clocks.
  - wrap is high when i_out=192; out_valid stays 1.
- fcw_load with fcw_in=0x2000 mid-stream → after 2 edges, i_out steps by 2 table entries (200,171,100,29,0,29,100,171) and wrap occurs every 8 clocks.
- Toggle en low for 3 cycles at i_out=138 → i_out/q_out hold, out_valid=0, wrap=0; on resume the next sample is 100.
- phase_sync with fcw_load same cycle (fcw_in=0x3000) → next sample 200/100, then i_out=138 (k=3).
- Assert rst_n=0 for one cycle during streaming with fcw=0 previously loaded → outputs 0, out_valid=0; after release the default FCW is restored and the first sample is 200/100.
- Non-default build with IDX_W=6, PHASE_W=20, DATA_W=10, AMP=500, OFFSET=511 → i_out peak 1011, trough 11, period 64 clocks; q_out lags i_out by 16 samples.
